// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Holds the parameter defaults and the output-mode encoding, which is
// derived from the active divisor N:
//   N == 0      -> MODE_OFF    (q held low, div_err raised)
//   N == 1      -> MODE_BYPASS (q follows clk)
//   N even >= 2 -> MODE_EVEN   (q is the posedge phase)
//   N odd  >= 3 -> MODE_ODD    (q is the posedge phase ANDed with its negedge copy)
package freq_div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 3;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_EVEN   = 2'd2,
    MODE_ODD    = 2'd3
  } mode_e;

  // Callers zero-extend the divisor to 32 bits so one function serves any WIDTH.
  function automatic mode_e mode_of(input logic [31:0] n);
    mode_e m;
    if (n == 32'd0) begin
      m = MODE_OFF;
    end else if (n == 32'd1) begin
      m = MODE_BYPASS;
    end else if (n[0] == 1'b0) begin
      m = MODE_EVEN;
    end else begin
      m = MODE_ODD;
    end
    return m;
  endfunction

endpackage

// File: rtl/div_core.sv
// Posedge half of the divider: period counter, half-period phase compare,
// active/pending divisor registers and the mode register.
// Ports:
//   clk, rst (sync, active-low), en (run enable), load (capture div),
//   div     - requested divisor
//   qp      - posedge phase, high while cnt < ceil(N/2)
//   tick    - one-cycle pulse at cnt == 0 (constant 1 in bypass)
//   run     - en as sampled on the last posedge
//   late    - even divisor running half a cycle behind (see below)
//   mode    - output mode of the active divisor
//   div_err - active divisor is zero
module div_core
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             qp,
  output logic             tick,
  output logic             run,
  output logic             late,
  output mode_e            mode,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam mode_e            RST_MODE = mode_of(32'(DEFAULT_DIV));

  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] act_div_r, act_div_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             pend_v_r, pend_v_s;
  logic             qp_r, qp_s;
  logic             tick_r, tick_s;
  logic             run_r;
  logic             late_r, late_s;
  mode_e            mode_r, mode_s;
  logic             div_err_r, div_err_s;
  logic             wrap_s, apply_s, start_s;
  logic [WIDTH:0]   half_s;

  // Next-state: period boundary detection, divisor hand-over, counter and phase.
  always_comb begin
    cnt_s     = ZERO;
    qp_s      = 1'b0;
    tick_s    = 1'b0;
    late_s    = late_r;
    act_div_s = act_div_r;
    apply_s   = 1'b0;

    // The wrap posedge (N-1 -> 0) is the only in-run period boundary.
    if (run_r && en && (act_div_r != ZERO) && (cnt_r == act_div_r - ONE)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end

    // A stopped divider (en low) or a zero divisor has no period in progress,
    // so a pending divisor may be taken on any posedge there.
    if (pend_v_r && (!en || wrap_s || (act_div_r == ZERO))) begin
      apply_s   = 1'b1;
      act_div_s = pend_r;
    end else begin
      apply_s   = 1'b0;
      act_div_s = act_div_r;
    end

    // A load on the apply posedge hands over the old value and stays pending.
    pend_s    = load ? div : pend_r;
    pend_v_s  = load | (pend_v_r & ~apply_s);

    mode_s    = mode_of(32'(act_div_s));
    div_err_s = (act_div_s == ZERO);
    // WIDTH+1 bits so that N = 2^WIDTH-1 yields 2^(WIDTH-1), not 0.
    half_s    = ({1'b0, act_div_s} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    start_s   = !run_r || apply_s || wrap_s;

    // An odd period's q ends half a cycle after its wrap posedge. An even
    // divisor following it is output from the negedge copy so its first high
    // phase cannot start before the odd low phase is complete; it keeps that
    // phase until the divider is stopped.
    if (!en) begin
      late_s = 1'b0;
    end else if (apply_s) begin
      late_s = (mode_s == MODE_EVEN) && ((mode_r == MODE_ODD) || late_r);
    end else begin
      late_s = late_r;
    end

    if (!en) begin
      cnt_s  = ZERO;
      qp_s   = 1'b0;
      tick_s = 1'b0;
    end else begin
      case (mode_s)
        MODE_OFF: begin
          cnt_s  = ZERO;
          qp_s   = 1'b0;
          tick_s = 1'b0;
        end
        MODE_BYPASS: begin
          cnt_s  = ZERO;
          qp_s   = 1'b0;
          tick_s = 1'b1;
        end
        MODE_EVEN, MODE_ODD: begin
          if (start_s) begin
            cnt_s  = ZERO;
            qp_s   = 1'b1;
            tick_s = 1'b1;
          end else begin
            cnt_s  = cnt_r + ONE;
            qp_s   = ({1'b0, cnt_s} < half_s);
            tick_s = 1'b0;
          end
        end
        default: begin
          cnt_s  = ZERO;
          qp_s   = 1'b0;
          tick_s = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r     <= ZERO;
      act_div_r <= RST_DIV;
      pend_r    <= ZERO;
      pend_v_r  <= 1'b0;
      qp_r      <= 1'b0;
      tick_r    <= 1'b0;
      run_r     <= 1'b0;
      late_r    <= 1'b0;
      mode_r    <= RST_MODE;
      div_err_r <= (RST_DIV == ZERO);
    end else begin
      cnt_r     <= cnt_s;
      act_div_r <= act_div_s;
      pend_r    <= pend_s;
      pend_v_r  <= pend_v_s;
      qp_r      <= qp_s;
      tick_r    <= tick_s;
      run_r     <= en;
      late_r    <= late_s;
      mode_r    <= mode_s;
      div_err_r <= div_err_s;
    end
  end

  assign qp      = qp_r;
  assign tick    = tick_r;
  assign run     = run_r;
  assign late    = late_r;
  assign mode    = mode_r;
  assign div_err = div_err_r;

endmodule

// File: rtl/freq_div_n.sv
// Programmable integer clock divider with 50% duty for every N >= 1.
// Ports:
//   clk     - sole clock (posedge active; negedge feeds the odd-N phase flop)
//   rst     - synchronous active-low reset
//   en      - run enable
//   load    - capture div as the pending divisor
//   div     - requested divisor N
//   q       - divided clock
//   tick    - one-cycle pulse at the start of each q period
//   div_err - active divisor is zero
module freq_div_n
  import freq_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             q,
  output logic             tick,
  output logic             div_err
);

  logic  qp_s, tick_s, run_s, late_s, div_err_s;
  mode_e mode_s;
  logic  qn_r, live_r, q_s;

  div_core #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .div     (div),
    .qp      (qp_s),
    .tick    (tick_s),
    .run     (run_s),
    .late    (late_s),
    .mode    (mode_s),
    .div_err (div_err_s)
  );

  // Negedge copy of the phase; live_r also gates q so reset silences q within half a cycle.
  always_ff @(negedge clk) begin
    if (!rst) begin
      qn_r   <= 1'b0;
      live_r <= 1'b0;
    end else begin
      qn_r   <= qp_s;
      live_r <= 1'b1;
    end
  end

  // Output mux selected by the registered mode of the active divisor.
  always_comb begin
    q_s = 1'b0;
    case (mode_s)
      MODE_BYPASS: q_s = clk & run_s;
      MODE_EVEN:   q_s = late_s ? qn_r : qp_s;
      MODE_ODD:    q_s = qp_s & qn_r;
      MODE_OFF:    q_s = 1'b0;
      default:     q_s = 1'b0;
    endcase
  end

  assign q       = q_s & live_r;
  assign tick    = tick_s;
  assign div_err = div_err_s;

endmodule

// File: doc/freq_div_n.md
FREQ_DIV_N -- requirements
Module: freq_div_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: divisor and counter width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 3: divisor in effect after reset.
REQ-003 SHALL have port clk  input  1  sole clock; the posedge is the active edge; the negedge is used only per REQ-012.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  divider run enable.
REQ-006 SHALL have port load  input  1  capture div into the pending register this cycle.
REQ-007 SHALL have port div  input  WIDTH  requested divisor N, unsigned.
REQ-008 SHALL have port q  output  1  divided clock, 50% duty for every N>=1.
REQ-009 SHALL have port tick  output  1  one-clk-cycle pulse at the start of each q period.
REQ-010 SHALL have port div_err  output  1  high while the active divisor is 0.

Function
REQ-011 SHALL run counter cnt from 0 to N-1 on posedges while en=1, wrapping from N-1 to 0.
REQ-012 SHALL form the posedge phase qp = (cnt < ceil(N/2)); for even N, q=qp; for odd N>=3, q=qp AND qn, where qn is qp captured on the negedge, giving a high time of exactly N/2 clk periods.
REQ-013 SHALL, for N=1, drive q=clk through a bypass mux while en=1, and drive tick=1 continuously.
REQ-014 SHALL, for N=0, hold q=0 and tick=0, freeze cnt at 0, and assert div_err=1.
REQ-015 SHALL assert tick for one cycle when cnt=0 and en=1 (N>=2).
REQ-016 SHALL, on load=1, capture div into the pending register and set pend_v=1; a later load before the apply point overwrites the pending value.
REQ-017 SHALL apply the pending divisor only at a period boundary: the posedge where cnt wraps N-1 -> 0, or any posedge with en=0; pend_v clears on apply.
REQ-018 SHALL, on simultaneous load and apply, apply the old pending value and keep the new value pending.
REQ-019 SHALL produce no q pulse shorter than min(old,new) half-periods across a divisor change.
REQ-020 SHALL, when en=0 is sampled, force cnt=0, qp=0 and tick=0 at that posedge (q low by the following negedge).
REQ-021 SHALL, on en rising, drive q high for the first time at the first posedge with en sampled high; that posedge is cnt=0 with tick=1.
REQ-022 SHALL compute the half-period threshold as (N+1)>>1 in WIDTH+1 bits, so that N=2^WIDTH-1 does not overflow.

Reset
REQ-023 SHALL, on rst=0 sampled at posedge, set cnt=0, qp=0, tick=0, the active divisor to DEFAULT_DIV, and pend_v=0.
REQ-024 SHALL clear the negedge register qn synchronously on the negedge while rst=0, so that q=0 within half a cycle of reset.
REQ-025 SHALL let reset override en and load, and abort any mid-period or pending change.
REQ-026 SHALL set div_err to reflect DEFAULT_DIV==0 after reset.

Structure
REQ-027 SHALL place WIDTH and DEFAULT_DIV defaults, and the mode encoding (BYPASS, EVEN, ODD, OFF derived from N), in the shared package freq_div_pkg.
REQ-028 SHALL implement the counter, the phase compare and the divisor registers in one sub-module div_core; freq_div_n holds the negedge flop and the output mux.
REQ-029 SHALL compute the mode from the active divisor registered at the apply point, never from the div input directly.

Verification
REQ-030 SHALL verify: clk 10 ns, rst low 20 ns, en=1, N=3 -> q period 30 ns, high 15 ns, tick every 3rd cycle.
REQ-031 SHALL verify: load div=4 mid-period at N=3 -> the current 30 ns period completes, then q has a 40 ns period with 20 ns high and no runt pulse.
REQ-032 SHALL verify: div=1 -> q tracks clk and tick is constant 1; div=0 -> q=0 and div_err=1; then div=6 -> a 60 ns period and div_err=0.
REQ-033 SHALL verify: en dropped at cnt=1, N=5 -> q=0 within one cycle; en restored -> q high and tick=1 on the first posedge.
REQ-034 SHALL verify: rst asserted mid-high phase with load pending -> q=0 within half a cycle; after release the divisor is 3 and pend_v=0.
REQ-035 SHALL verify: WIDTH=8, N=255 -> q high 127.5 cycles and low 127.5 cycles, with no threshold overflow.
